// File: rtl/sum_accumulator_if.sv
// Sum stream in (sync/din) and per-period total out (dout/dout_valid/sync_out/sync_err).
// Latency: n/a (signal bundle only).
// Backpressure: none; every field is valid or pulsed each cycle.
interface sum_accumulator_if #(
    parameter int INPUT_WIDTH  = 7,
    parameter int OUTPUT_WIDTH = 11
);
    logic                    sync;
    logic [INPUT_WIDTH-1:0]  din;
    logic [OUTPUT_WIDTH-1:0] dout;
    logic                    dout_valid;
    logic                    sync_out;
    logic                    sync_err;

    modport master (
        output sync, din,
        input  dout, dout_valid, sync_out, sync_err
    );

    modport slave (
        input  sync, din,
        output dout, dout_valid, sync_out, sync_err
    );
endinterface

// File: rtl/sum_accumulator.sv
// Integrates din over 2^ACC_LEN_BITS-sample periods aligned to sync; dumps one widened total per period.
// Latency: total registered one cycle after the period's last sample; sync_err one cycle after the bad sync.
// Backpressure: none; one din accepted every cycle.
module sum_accumulator #(
    parameter int    INPUT_WIDTH  = 7,
    parameter int    ACC_LEN_BITS = 4,
    parameter string IS_SIGNED    = "TRUE"
) (
    input  logic              clk,
    input  logic              rst,
    sum_accumulator_if.slave  bus
);
    localparam int OUTPUT_WIDTH = INPUT_WIDTH + ACC_LEN_BITS;
    localparam int ACC_LEN      = 1 << ACC_LEN_BITS;
    localparam int CNT_W        = (ACC_LEN_BITS > 0) ? ACC_LEN_BITS : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ACC_LEN - 1);
    localparam bit   SIGN_EXT   = (IS_SIGNED == "TRUE");

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                  state, state_n;
    logic [OUTPUT_WIDTH-1:0] acc, acc_n;
    logic [CNT_W-1:0]        count, count_n;
    logic                    first, first_n;
    logic [OUTPUT_WIDTH-1:0] dout_q, dout_n;
    logic                    dv_q, dv_n;
    logic                    so_q, so_n;
    logic                    err_q, err_n;
    logic [OUTPUT_WIDTH-1:0] din_ext;
    logic                    start;
    logic                    dump;

    always_comb begin
        din_ext = {OUTPUT_WIDTH{SIGN_EXT & bus.din[INPUT_WIDTH-1]}};
        din_ext[INPUT_WIDTH-1:0] = bus.din;
    end

    always_comb begin
        state_n = state;
        acc_n   = acc;
        count_n = count;
        first_n = first;
        dout_n  = dout_q;
        dv_n    = 1'b0;
        so_n    = 1'b0;
        err_n   = 1'b0;
        start   = 1'b0;
        dump    = 1'b0;

        unique case (state)
            IDLE: begin
                start = bus.sync;
            end
            ACCUM: begin
                // sync always wins, even on the last sample of a period
                if (bus.sync) begin
                    start = 1'b1;
                    err_n = (count != '0);
                end else if (count == LAST) begin
                    dump = 1'b1;
                end else begin
                    acc_n   = acc + din_ext;
                    count_n = count + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        if (start) begin
            state_n = ACCUM;
            acc_n   = din_ext;
            count_n = CNT_W'(1);
            first_n = 1'b1;
            // a single-sample period completes on the very sample that opened it
            if (ACC_LEN == 1) begin
                dump = 1'b1;
            end
        end

        if (dump) begin
            dout_n  = (start ? '0 : acc) + din_ext;
            dv_n    = 1'b1;
            so_n    = start | first;
            first_n = 1'b0;
            acc_n   = '0;
            count_n = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            count  <= '0;
            first  <= 1'b0;
            dout_q <= '0;
            dv_q   <= 1'b0;
            so_q   <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_n;
            acc    <= acc_n;
            count  <= count_n;
            first  <= first_n;
            dout_q <= dout_n;
            dv_q   <= dv_n;
            so_q   <= so_n;
            err_q  <= err_n;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dv_q;
    assign bus.sync_out   = so_q;
    assign bus.sync_err   = err_q;
endmodule
